issue_scoreboard_ctrl: RTL
==========================

Name: issue_scoreboard_ctrl

Overview:
- Sits between instruction fetch and the decode stage.
- Issues one instruction per cycle over valid/ready handshakes on both sides.
- Tracks pending register writes in a 32-entry scoreboard and stalls on read-after-write (RAW) and write-after-write (WAW) hazards.
- On a jump, blocks fetch and raises a flush pulse so fetch can discard its wrong-path instruction.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired and never pending.
- REG_AW, 5, register index width.
- FLUSH_CYCLES, 2, cycles spent in FLUSH after a jump is accepted (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  controller accepts in_instr this cycle
- in_instr  in  32  raw instruction [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd
- out_valid  out  1  out_instr valid toward decode
- out_ready  in  1  decode accepts out_instr
- out_instr  out  32  registered issued instruction
- wb_valid  in  1  writeback completes a register write
- wb_reg  in  5  register being written back
- stall  out  1  high while in STALL state
- flush_req  out  1  one-cycle pulse on entry to FLUSH
- pending_count  out  6  number of set scoreboard bits (0..31)

Behaviour:
- Classification by opcode:
  - 000000 R-type: reads rs and rt; writes rd.
  - 000001 I-type: reads rs; writes rt.
  - 000010 J-type: no reads, no write; triggers FLUSH.
  - Any other opcode: NOP; no reads, no write, issued normally.
- Hazard: any read source, or the destination, has its pending bit set. Hazards are evaluated against pending bits after this cycle's writeback clear, so a writeback to the needed register unblocks issue in the same cycle. Index 0 never hazards.
- Accept condition: in_ready = (state==RUN) && !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
- On accept:
  - out_instr <= in_instr and out_valid <= 1 next edge.
  - Pending[dest] <= 1 if dest != 0.
- Output register:
  - out_valid clears on out_valid && out_ready with no new accept.
  - out_instr holds stable while out_valid && !out_ready.
- Writeback: wb_valid clears pending[wb_reg]. If the same cycle both sets and clears one index, the set wins. Writeback to a non-pending register or to register 0 has no effect.
- FSM states:
  - RUN → STALL when in_valid && hazard.
  - RUN → FLUSH when a J-type instruction is accepted.
  - STALL → RUN when the hazard clears or in_valid drops. in_ready is 0 while in STALL, so the instruction is accepted one cycle after returning to RUN.
  - FLUSH: counter loads FLUSH_CYCLES-1 and decrements each cycle. Returns to RUN after the cycle in which the counter reads 0. in_ready=0 throughout.
- flush_req is high only in the first FLUSH cycle.
- pending_count is registered and equals the popcount of the scoreboard after the same edge's updates.
- Reset (async assert, synchronous release by the surrounding reset logic):
  - state=RUN
  - all pending bits=0
  - out_valid=0
  - out_instr=0
  - stall=0
  - flush_req=0
  - pending_count=0
  - FLUSH counter=0
- Reset mid-FLUSH or mid-STALL returns to RUN with an empty scoreboard.
- Backpressure: out_ready low with out_valid high blocks acceptance. The scoreboard and FSM are otherwise unaffected, and writebacks are still processed.

Decomposition:
- Shared package holds:
  - opcode localparams OP_RTYPE=6'b000000, OP_ITYPE=6'b000001, OP_JTYPE=6'b000010
  - field bit positions
  - state encoding RUN/STALL/FLUSH
- Natural sub-module: scoreboard_regs, containing the pending-bit array, set/clear priority, hazard lookup for two reads plus one destination, and popcount.
- The FSM and the handshake logic stay in the top module.

Test Plan:
- Back-to-back independent R-types, out_ready=1: add r3←r1,r2 then r6←r4,r5 → both issue on consecutive cycles; pending_count 1 then 2; stall stays 0.
- RAW stall: R-type writing r3, then R-type reading r3; wb_valid with wb_reg=3 asserted 4 cycles later → stall=1 for the intervening cycles; the second instruction is accepted in the first RUN cycle after the writeback; pending_count returns to 1.
- Same-cycle writeback bypass: r3 pending; wb_reg=3 in the same cycle that an instruction reading r3 is presented in RUN → accepted with no stall.
- Jump flush with FLUSH_CYCLES=2: accept opcode 000010 → flush_req is a 1-cycle pulse; in_ready=0 for 2 cycles; the next valid instruction is accepted on the third cycle.
- Backpressure plus register 0: hold out_ready=0 → out_instr stable and in_ready=0; an I-type with rt=0 issued afterwards never sets a pending bit (pending_count unchanged).
- Async reset mid-STALL: assert rst_n=0 with 3 pending bits while stalled → out_valid, stall and pending_count drop to 0 immediately; after release, a previously blocked instruction issues without stalling.

Source files
------------

// File: rtl/issue_scoreboard_ctrl_pkg.sv
// Shared definitions for the issue controller: opcodes, instruction field positions, FSM encoding.
package issue_scoreboard_ctrl_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ITYPE = 6'b000001;
    localparam logic [5:0] OP_JTYPE = 6'b000010;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/issue_scoreboard_ctrl_scoreboard_regs.sv
// Pending-write scoreboard: per-register pending bits, hazard lookup and registered popcount.
module issue_scoreboard_ctrl_scoreboard_regs
    import issue_scoreboard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_reg_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_reg_i,
    input  logic              rs_en_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic              rt_en_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              dst_en_i,
    input  logic [REG_AW-1:0] dst_i,
    output logic              hazard_o,
    output logic [5:0]        pending_count_o
);
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_clr;
    logic [NUM_REGS-1:0] pend_d;
    logic [5:0]          count_q;
    logic [5:0]          count_d;

    // The clear is applied first so that a same-cycle set of the same index wins.
    always_comb begin
        pend_clr = pend_q;
        if (clr_en_i) pend_clr[clr_reg_i] = 1'b0;
        pend_d = pend_clr;
        if (set_en_i && (set_reg_i != '0)) pend_d[set_reg_i] = 1'b1;
        count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) count_d = count_d + 6'(pend_d[i]);
    end

    // Lookup uses the post-writeback view so a completing write unblocks issue immediately.
    assign hazard_o = (rs_en_i  && (rs_i  != '0) && pend_clr[rs_i])  ||
                      (rt_en_i  && (rt_i  != '0) && pend_clr[rt_i])  ||
                      (dst_en_i && (dst_i != '0) && pend_clr[dst_i]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign pending_count_o = count_q;
endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller between fetch and decode: RAW/WAW stalls via the scoreboard, jump flush sequencing.
module issue_scoreboard_ctrl
    import issue_scoreboard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_reg,
    output logic              stall,
    output logic              flush_req,
    output logic [5:0]        pending_count,
    output logic [1:0]        dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds its data stable while valid is high and ready is low.
    state_e      state_q;
    logic        stall_q;
    logic        flush_req_q;
    logic [3:0]  flush_cnt_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;

    logic              rs_en, rt_en, dst_en, is_jump;
    logic [REG_AW-1:0] dst;
    logic [5:0]        opcode;
    logic              hazard;
    logic              accept;

    assign opcode = in_instr[OPC_HI:OPC_LO];

    always_comb begin
        rs_en   = 1'b0;
        rt_en   = 1'b0;
        dst_en  = 1'b0;
        is_jump = 1'b0;
        dst     = '0;
        case (opcode)
            OP_RTYPE: begin rs_en = 1'b1; rt_en = 1'b1; dst_en = 1'b1; dst = in_instr[RD_HI:RD_LO]; end
            OP_ITYPE: begin rs_en = 1'b1; dst_en = 1'b1; dst = in_instr[RT_HI:RT_LO]; end
            OP_JTYPE: is_jump = 1'b1;
            default:  ;
        endcase
    end

    issue_scoreboard_ctrl_scoreboard_regs u_sb (
        .clk             (clk),
        .rst_n           (rst_n),
        .set_en_i        (accept && dst_en),
        .set_reg_i       (dst),
        .clr_en_i        (wb_valid),
        .clr_reg_i       (wb_reg),
        .rs_en_i         (rs_en),
        .rs_i            (in_instr[RS_HI:RS_LO]),
        .rt_en_i         (rt_en),
        .rt_i            (in_instr[RT_HI:RT_LO]),
        .dst_en_i        (dst_en),
        .dst_i           (dst),
        .hazard_o        (hazard),
        .pending_count_o (pending_count)
    );

    assign in_ready = (state_q == ST_RUN) && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_q     <= 1'b0;
            flush_req_q <= 1'b0;
            flush_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
        end else begin
            flush_req_q <= 1'b0;
            if (accept) begin
                out_instr_q <= in_instr;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_RUN: begin
                    if (accept && is_jump) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                        flush_req_q <= 1'b1;
                    end else if (in_valid && hazard) begin
                        state_q <= ST_STALL;
                        stall_q <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!hazard || !in_valid) begin
                        state_q <= ST_RUN;
                        stall_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) state_q <= ST_RUN;
                    else                   flush_cnt_q <= flush_cnt_q - 4'd1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign stall     = stall_q;
    assign flush_req = flush_req_q;
    assign dbg_state = state_q;
endmodule
